lif_network: RTL and testbench

Parametrised leaky integrate-and-fire spiking network: the successor to the fixed two-neuron/two-synapse top level. It holds `N` neurons with a programmable `N`×`N` signed synaptic weight matrix, per-neuron refractory counters, an external stimulus input and a saturating network spike counter. It instantiates under the `tt_um_*` wrapper, which maps `ui_in`/`uio_in` onto the configuration and stimulus ports and `uo_out` onto `spike_out`/`spike_count`.

---
 rtl/lif_network.sv | 149 ++++++++++++++
 tb/tb_lif_network.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_network.sv
// Leaky integrate-and-fire network: N neurons, programmable NxN signed weights,
// per-neuron refractory counters, external stimulus and a saturating spike counter.
module lif_network #(
    parameter int N          = 4,
    parameter int V_WIDTH    = 8,
    parameter int W_WIDTH    = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int EXT_GAIN   = 32,
    parameter int REFRACT    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       cfg_we,
    input  logic [$clog2(N*N)-1:0]     cfg_addr,
    input  logic [W_WIDTH-1:0]         cfg_data,
    input  logic [V_WIDTH-1:0]         threshold,
    input  logic [N-1:0]               ext_in,
    output logic [N-1:0]               spike_out,
    output logic                       spike_any,
    output logic [15:0]                spike_count
);

    localparam int AW = $clog2(N*N);
    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int SW = V_WIDTH + $clog2(N) + W_WIDTH + 1;
    localparam int PW = $clog2(N + 1);
    localparam logic [AW:0]           NUM_W = (AW + 1)'(N * N);
    localparam logic signed [SW-1:0] V_MAX = {{(SW - V_WIDTH){1'b0}}, {V_WIDTH{1'b1}}};

    logic [V_WIDTH-1:0] v_q    [N];
    logic [V_WIDTH-1:0] v_d    [N];
    logic [RW-1:0]      refr_q [N];
    logic [RW-1:0]      refr_d [N];
    logic [N-1:0]       spike_q;
    logic [N-1:0]       spike_d;
    logic [15:0]        cnt_q;
    logic [15:0]        cnt_d;
    logic [W_WIDTH-1:0] w_q    [N*N];
    logic [V_WIDTH-1:0] vnext_s [N];

    // Negative results floor at zero, oversized results pin at the top of the range.
    function automatic logic [V_WIDTH-1:0] clamp_v(input logic signed [SW-1:0] x);
        logic [V_WIDTH-1:0] r;
        if (x[SW-1]) begin
            r = '0;
        end else if (x > V_MAX) begin
            r = {V_WIDTH{1'b1}};
        end else begin
            r = x[V_WIDTH-1:0];
        end
        return r;
    endfunction

    // Leaky integration of weighted registered spikes plus external drive.
    always_comb begin
        logic signed [SW-1:0] cur;
        logic signed [SW-1:0] raw;
        cur = '0;
        raw = '0;
        for (int i = 0; i < N; i++) begin
            cur = ext_in[i] ? SW'(EXT_GAIN) : '0;
            for (int j = 0; j < N; j++) begin
                if (spike_q[j]) begin
                    cur = cur + {{(SW - W_WIDTH){w_q[i*N+j][W_WIDTH-1]}}, w_q[i*N+j]};
                end else begin
                    cur = cur;
                end
            end
            raw = {{(SW - V_WIDTH){1'b0}}, v_q[i]}
                - {{(SW - V_WIDTH){1'b0}}, v_q[i] >> LEAK_SHIFT}
                + cur;
            vnext_s[i] = clamp_v(raw);
        end
    end

    // Per-neuron firing decision and saturating network spike count.
    always_comb begin
        logic [PW-1:0] pop;
        logic [16:0]   cnt_sum;
        pop     = '0;
        cnt_sum = '0;
        spike_d = spike_q;
        for (int i = 0; i < N; i++) begin
            v_d[i]    = v_q[i];
            refr_d[i] = refr_q[i];
            if (!ena) begin
                spike_d[i] = spike_q[i];
            end else if (refr_q[i] != '0) begin
                v_d[i]     = '0;
                refr_d[i]  = refr_q[i] - RW'(1);
                spike_d[i] = 1'b0;
            end else if (vnext_s[i] >= threshold) begin
                v_d[i]     = '0;
                refr_d[i]  = RW'(REFRACT);
                spike_d[i] = 1'b1;
            end else begin
                v_d[i]     = vnext_s[i];
                spike_d[i] = 1'b0;
            end
            pop = pop + PW'(spike_d[i]);
        end
        cnt_sum = {1'b0, cnt_q} + 17'(pop);
        if (!ena) begin
            cnt_d = cnt_q;
        end else if (cnt_sum[16]) begin
            cnt_d = 16'hFFFF;
        end else begin
            cnt_d = cnt_sum[15:0];
        end
    end

    // Neuron state and spike counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                v_q[i]    <= '0;
                refr_q[i] <= '0;
            end
            spike_q <= '0;
            cnt_q   <= 16'h0000;
        end else begin
            for (int i = 0; i < N; i++) begin
                v_q[i]    <= v_d[i];
                refr_q[i] <= refr_d[i];
            end
            spike_q <= spike_d;
            cnt_q   <= cnt_d;
        end
    end

    // Weight RAM; a write lands after this edge's update has read the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N * N; k++) begin
                w_q[k] <= '0;
            end
        end else if (cfg_we && ({1'b0, cfg_addr} < NUM_W)) begin
            w_q[cfg_addr] <= cfg_data;
        end else begin
            w_q[0] <= w_q[0];
        end
    end

    assign spike_out   = spike_q;
    assign spike_any   = |spike_q;
    assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_network.sv
// Randomised and directed bench for lif_network against an integer reference model.
module tb_lif_network;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [3:0]  cfg_data;
    logic [7:0]  threshold;
    logic [3:0]  ext_in;
    logic [3:0]  spike_out;
    logic        spike_any;
    logic [15:0] spike_count;

    int n_checks = 0;
    int n_fail   = 0;

    int mv [4];
    int mr [4];
    int ms [4];
    int mw [16];
    int mcnt;

    lif_network dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .threshold   (threshold),
        .ext_in      (ext_in),
        .spike_out   (spike_out),
        .spike_any   (spike_any),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 0; mr[i] = 0; ms[i] = 0;
        end
        for (int k = 0; k < 16; k++) mw[k] = 0;
        mcnt = 0;
    endfunction

    // One clock edge of the network, straight from the neuron rules.
    function automatic void model_edge();
        int ns [4];
        int cur, raw, pop;
        if (ena === 1'b1) begin
            pop = 0;
            for (int i = 0; i < 4; i++) begin
                if (mr[i] != 0) begin
                    mv[i] = 0; mr[i] = mr[i] - 1; ns[i] = 0;
                end else begin
                    cur = ext_in[i] ? 32 : 0;
                    for (int j = 0; j < 4; j++) if (ms[j] != 0) cur += mw[i*4+j];
                    raw = mv[i] - mv[i] / 8 + cur;
                    if (raw < 0) raw = 0;
                    else if (raw > 255) raw = 255;
                    if (raw >= int'(threshold)) begin
                        ns[i] = 1; mv[i] = 0; mr[i] = 2;
                    end else begin
                        ns[i] = 0; mv[i] = raw;
                    end
                end
                pop += ns[i];
            end
            ms   = ns;
            mcnt = (mcnt + pop > 65535) ? 65535 : mcnt + pop;
        end
        if (cfg_we === 1'b1)
            mw[cfg_addr] = (cfg_data >= 4'd8) ? int'(cfg_data) - 16 : int'(cfg_data);
    endfunction

    function automatic logic [3:0] m_spk();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (ms[i] != 0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 4'd0;
        threshold = 8'd100; ext_in = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ena = 1'($urandom); cfg_we = 1'b1; cfg_addr = 4'($urandom);
            cfg_data = 4'($urandom); threshold = 8'($urandom); ext_in = 4'($urandom);
            @(negedge clk);
            n_checks++;
            if (spike_out !== 4'b0000 || spike_any !== 1'b0 || spike_count !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_hold: spike_out=%b any=%b count=%0d, expected 0000 0 0",
                         spike_out, spike_any, spike_count);
            end
        end
    endtask

    task automatic test_charge();
        logic [3:0] exp_s;
        int exp_c = 0;
        do_reset();
        threshold = 8'd100; ext_in = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_s = (k == 4 || k == 10 || k == 16) ? 4'b0001 : 4'b0000;
            if (exp_s[0]) exp_c++;
            n_checks++;
            if (spike_out !== exp_s || spike_any !== (|exp_s) || spike_count !== 16'(exp_c)) begin
                n_fail++;
                $display("FAIL charge edge %0d: spike_out=%b any=%b count=%0d, expected %b %b %0d",
                         k, spike_out, spike_any, spike_count, exp_s, |exp_s, exp_c);
            end
        end
    endtask

    task automatic test_coupling();
        logic prev0 = 1'b0;
        do_reset();
        threshold = 8'd100; ext_in = 4'b0001;
        cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 4'd7;
        tick();
        cfg_we = 1'b0;
        tick(); tick();
        threshold = 8'd5;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (spike_out[1] !== prev0 || spike_out !== m_spk() || spike_count !== 16'(mcnt)) begin
                n_fail++;
                $display("FAIL coupling step %0d: spike_out=%b count=%0d, expected %b (n1=%b) %0d",
                         k, spike_out, spike_count, m_spk(), prev0, mcnt);
            end
            prev0 = spike_out[0];
        end
    endtask

    task automatic test_inhibit_clamp();
        bit found = 1'b0;
        do_reset();
        threshold = 8'd255; ext_in = 4'b0010;
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 4'h8;
        tick();
        cfg_we = 1'b0;
        for (int k = 0; k < 120 && !found; k++) begin
            tick();
            n_checks++;
            if (spike_out !== m_spk() || spike_out[0] !== 1'b0 || spike_count !== 16'(mcnt)) begin
                n_fail++;
                $display("FAIL clamp step %0d: spike_out=%b count=%0d, expected %b %0d",
                         k, spike_out, spike_count, m_spk(), mcnt);
            end
            if (spike_out[1] === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL clamp_crossing: neuron 1 spike seen=0, required 1");
        end
        tick();
        threshold = 8'd1; ext_in = 4'b0000;
        tick();
        n_checks++;
        if (spike_out !== 4'b0000) begin
            n_fail++;
            $display("FAIL inhibit_no_wrap: spike_out=%b, expected 0000", spike_out);
        end
    endtask

    task automatic test_threshold_zero();
        logic [3:0] exp_s;
        int exp_c = 0;
        do_reset();
        threshold = 8'd0; ext_in = 4'b0000;
        cfg_we = 1'b1; cfg_addr = 4'd15; cfg_data = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            cfg_we = 1'b0;
            exp_s = (k % 3 == 1) ? 4'b1111 : 4'b0000;
            if (exp_s[0]) exp_c += 4;
            n_checks++;
            if (spike_out !== exp_s || spike_count !== 16'(exp_c)) begin
                n_fail++;
                $display("FAIL thr0 edge %0d: spike_out=%b count=%0d, expected %b %0d",
                         k, spike_out, spike_count, exp_s, exp_c);
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        threshold = 8'd100; ext_in = 4'b0001;
        tick(); tick();
        ena = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 4'd7;
        for (int k = 0; k < 5; k++) begin
            tick();
            cfg_we = 1'b0;
            n_checks++;
            if (spike_out !== 4'b0000 || spike_count !== 16'd0) begin
                n_fail++;
                $display("FAIL freeze_hold %0d: spike_out=%b count=%0d, expected 0000 0",
                         k, spike_out, spike_count);
            end
        end
        ena = 1'b1; threshold = 8'd5;
        tick();
        n_checks++;
        if (spike_out !== 4'b0001) begin
            n_fail++;
            $display("FAIL freeze_resume: spike_out=%b, expected 0001", spike_out);
        end
        tick();
        n_checks++;
        if (spike_out !== 4'b0010 || spike_count !== 16'd2) begin
            n_fail++;
            $display("FAIL freeze_weight: spike_out=%b count=%0d, expected 0010 2",
                     spike_out, spike_count);
        end
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (spike_out !== 4'b0010 || spike_count !== 16'd2) begin
                n_fail++;
                $display("FAIL pulse_hold %0d: spike_out=%b count=%0d, expected 0010 2",
                         k, spike_out, spike_count);
            end
        end
        ena = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (spike_out !== m_spk() || spike_count !== 16'(mcnt)) begin
                n_fail++;
                $display("FAIL freeze_after %0d: spike_out=%b count=%0d, expected %b %0d",
                         k, spike_out, spike_count, m_spk(), mcnt);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        threshold = 8'd5; ext_in = 4'b0001;
        cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 4'd7;
        tick();
        cfg_we = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (spike_out !== 4'b0000 || spike_any !== 1'b0 || spike_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: spike_out=%b any=%b count=%0d, expected 0000 0 0",
                     spike_out, spike_any, spike_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (spike_out !== m_spk() || spike_count !== 16'(mcnt)) begin
                n_fail++;
                $display("FAIL weights_cleared %0d: spike_out=%b count=%0d, expected %b %0d",
                         k, spike_out, spike_count, m_spk(), mcnt);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            ena       = ($urandom_range(0, 7) != 0);
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_addr  = 4'($urandom);
            cfg_data  = 4'($urandom);
            threshold = 8'($urandom_range(10, 120));
            ext_in    = 4'($urandom);
            tick();
            n_checks++;
            if (spike_out !== m_spk() || spike_any !== (|m_spk()) || spike_count !== 16'(mcnt)) begin
                n_fail++;
                $display("FAIL random %0d: spike_out=%b count=%0d, expected %b %0d",
                         k, spike_out, spike_count, m_spk(), mcnt);
            end
        end
    endtask

    task automatic test_saturation();
        int extra = 0;
        do_reset();
        threshold = 8'd0; ext_in = 4'b0000;
        for (int k = 0; k < 52000 && extra < 10; k++) begin
            tick();
            if (mcnt == 65535) extra++;
            n_checks++;
            if (spike_count !== 16'(mcnt)) begin
                n_fail++;
                $display("FAIL saturate %0d: count=%0d, expected %0d", k, spike_count, mcnt);
            end
        end
        n_checks++;
        if (spike_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturate_final: count=%0d, expected 65535", spike_count);
        end
    endtask

    initial begin
        test_reset();
        test_charge();
        test_coupling();
        test_inhibit_clamp();
        test_threshold_zero();
        test_freeze();
        test_async_reset();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
